spmp_check_arb: RTL

SPMP_CHECK_ARB -- requirements
Module: spmp_check_arb

---
 rtl/ariane_pkg.sv | 7 +
 rtl/riscv_pkg.sv | 24 ++
 rtl/spmp_check_arb_pkg.sv | 17 +
 rtl/spmp_check_arb_rr.sv | 33 +++
 rtl/spmp_check_arb.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// Core-wide shared definitions; holds the SPMP requester port index.
package ariane_pkg;
   typedef enum logic {
      SPMP_PORT_IF  = 1'b0,
      SPMP_PORT_LSU = 1'b1
   } spmp_port_e;
endpackage

// File: rtl/riscv_pkg.sv
// Shared RISC-V architectural types: privilege levels, PMP access kinds,
// XLEN word and the access-fault exception causes.
package riscv;
   localparam int unsigned XLEN = 64;

   typedef logic [XLEN-1:0] xlen_t;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   typedef enum logic [2:0] {
      ACCESS_NONE  = 3'b000,
      ACCESS_READ  = 3'b001,
      ACCESS_WRITE = 3'b010,
      ACCESS_EXEC  = 3'b100
   } pmp_access_t;

   localparam xlen_t INSTR_ACCESS_FAULT = xlen_t'(1);
   localparam xlen_t LD_ACCESS_FAULT    = xlen_t'(5);
   localparam xlen_t ST_ACCESS_FAULT    = xlen_t'(7);
endpackage

// File: rtl/spmp_check_arb_pkg.sv
// Helpers for the shared SPMP checker arbiter.
package spmp_check_arb_pkg;
   import riscv::*;
   import ariane_pkg::*;

   localparam int unsigned NUM_PORTS = 2;

   // Store-class accesses (write bit set) fault as stores.
   function automatic xlen_t fault_cause(
      input spmp_port_e  port,
      input pmp_access_t acc
   );
      if (port == SPMP_PORT_IF) return INSTR_ACCESS_FAULT;
      if (acc[1]) return ST_ACCESS_FAULT;
      return LD_ACCESS_FAULT;
   endfunction
endpackage

// File: rtl/spmp_check_arb_rr.sv
// Two-requester round-robin arbiter with one-hot grant;
// the port not granted last wins a tie.
module spmp_rr_arb
   import spmp_check_arb_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [NUM_PORTS-1:0] req_i,
   output logic [NUM_PORTS-1:0] gnt_o
);

   // prio_q=1: port 1 wins ties
   logic prio_q;

   always_comb begin
      gnt_o = '0;
      if (en_i) begin
         if (req_i[0] && (!prio_q || !req_i[1]))
            gnt_o[0] = 1'b1;
         else if (req_i[1])
            gnt_o[1] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         prio_q <= 1'b0;
      else if (|gnt_o)
         prio_q <= gnt_o[0];
   end

endmodule

// File: rtl/spmp_check_arb.sv
// Shares one SPMP checker between fetch and LSU with a one-deep response.
// Optional SPMP_DENY_CNT_EN adds a saturating denied-response counter.
module spmp_check_arb
   import riscv::*;
   import ariane_pkg::*;
   import spmp_check_arb_pkg::*;
#(
   parameter int unsigned PLEN = 34
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [PLEN-1:0] if_addr_i,
   input  priv_lvl_t       if_priv_lvl_i,
   input  logic            if_v_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [PLEN-1:0] lsu_addr_i,
   input  priv_lvl_t       lsu_priv_lvl_i,
   input  logic            lsu_v_i,
   input  pmp_access_t     lsu_access_type_i,
   input  logic            lsu_hlvx_i,
   output logic [PLEN-1:0] chk_addr_o,
   output pmp_access_t     chk_access_type_o,
   output priv_lvl_t       chk_priv_lvl_o,
   output logic            chk_v_o,
   output logic            chk_hlvx_o,
   input  logic            chk_allow_i,
   output logic            if_resp_valid_o,
   input  logic            if_resp_ready_i,
   output logic            lsu_resp_valid_o,
   input  logic            lsu_resp_ready_i,
   output logic            resp_allow_o,
   output xlen_t           resp_cause_o
`ifdef SPMP_DENY_CNT_EN
   ,
   output logic [15:0]     deny_cnt_o
`endif
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RESP = 1'b1;

   logic [0:0]     state_q;
   spmp_port_e     owner_q;
   logic           allow_q;
   xlen_t          cause_q;

   logic [1:0]     gnt;
   logic           held;
   logic           owner_ready;
   logic           retire;
   logic           grant_en;
   spmp_port_e     gnt_port;
   xlen_t          cause_d;

   assign held        = (state_q == RESP);
   assign owner_ready = (owner_q == SPMP_PORT_LSU) ?
                        lsu_resp_ready_i : if_resp_ready_i;
   assign retire      = held && owner_ready && !flush_i;
   // Grant in the same cycle the held response retires.
   assign grant_en    = rst_ni && !flush_i && (!held || owner_ready);

   spmp_rr_arb u_rr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (grant_en),
      .req_i  ({lsu_valid_i, if_valid_i}),
      .gnt_o  (gnt)
   );

   assign if_ready_o  = gnt[0];
   assign lsu_ready_o = gnt[1];

   always_comb begin
      chk_addr_o        = '0;
      chk_access_type_o = ACCESS_NONE;
      chk_priv_lvl_o    = PRIV_LVL_U;
      chk_v_o           = 1'b0;
      chk_hlvx_o        = 1'b0;
      gnt_port          = SPMP_PORT_IF;
      unique case (1'b1)
         gnt[0]: begin
            chk_addr_o        = if_addr_i;
            chk_access_type_o = ACCESS_EXEC;
            chk_priv_lvl_o    = if_priv_lvl_i;
            chk_v_o           = if_v_i;
         end
         gnt[1]: begin
            chk_addr_o        = lsu_addr_i;
            chk_access_type_o = lsu_access_type_i;
            chk_priv_lvl_o    = lsu_priv_lvl_i;
            chk_v_o           = lsu_v_i;
            chk_hlvx_o        = lsu_hlvx_i;
            gnt_port          = SPMP_PORT_LSU;
         end
         default: ;
      endcase
   end

   assign cause_d = chk_allow_i ? '0 :
                    fault_cause(gnt_port, chk_access_type_o);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= SPMP_PORT_IF;
         allow_q <= 1'b0;
         cause_q <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else if (|gnt) begin
         state_q <= RESP;
         owner_q <= gnt_port;
         allow_q <= chk_allow_i;
         cause_q <= cause_d;
      end else if (retire) begin
         state_q <= IDLE;
      end
   end

   assign if_resp_valid_o  = held && (owner_q == SPMP_PORT_IF);
   assign lsu_resp_valid_o = held && (owner_q == SPMP_PORT_LSU);
   assign resp_allow_o     = held && allow_q;
   assign resp_cause_o     = held ? cause_q : '0;

`ifdef SPMP_DENY_CNT_EN
   logic [15:0] deny_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         deny_cnt_q <= '0;
      else if (retire && !allow_q && (deny_cnt_q != 16'hFFFF))
         deny_cnt_q <= deny_cnt_q + 16'd1;
   end

   assign deny_cnt_o = deny_cnt_q;
`endif

endmodule
